// File: rtl/ula_pixel_serializer.sv
// ULA pixel stage: latches fetched bitmap/attribute bytes, serializes the bitmap MSB-first
// and resolves each pixel to a 4-bit {bright, G, R, B} colour index for the video DAC.
module ula_pixel_serializer #(
    parameter int unsigned FLASH_BITS = 5,
    parameter int unsigned PIX_WIDTH  = 8
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       bm_ld,
    input  logic       at_ld,
    input  logic [7:0] vdata,
    input  logic       shift_ld,
    input  logic       disp_en,
    input  logic [2:0] border,
    input  logic       n_blank,
    input  logic       frame_sync,
    output logic [3:0] colour,
    output logic       flash_phase
);

    localparam int unsigned ATTR_W = 8;
    localparam int unsigned COL_W  = 4;
    localparam int unsigned BORD_W = 3;

    logic [PIX_WIDTH-1:0]  bm_hold_q,   bm_hold_d;
    logic [ATTR_W-1:0]     at_hold_q,   at_hold_d;
    logic [PIX_WIDTH-1:0]  shift_reg_q, shift_reg_d;
    logic [ATTR_W-1:0]     attr_reg_q,  attr_reg_d;
    logic                  disp_reg_q,  disp_reg_d;
    logic [BORD_W-1:0]     bord_reg_q,  bord_reg_d;
    logic [FLASH_BITS-1:0] flash_cnt_q, flash_cnt_d;
    logic [COL_W-1:0]      colour_q,    colour_d;
    logic                  pix_c;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bm_hold_q   <= '0;
            at_hold_q   <= '0;
            shift_reg_q <= '0;
            attr_reg_q  <= '0;
            disp_reg_q  <= 1'b0;
            bord_reg_q  <= '0;
            flash_cnt_q <= '0;
            colour_q    <= '0;
        end else begin
            bm_hold_q   <= bm_hold_d;
            at_hold_q   <= at_hold_d;
            shift_reg_q <= shift_reg_d;
            attr_reg_q  <= attr_reg_d;
            disp_reg_q  <= disp_reg_d;
            bord_reg_q  <= bord_reg_d;
            flash_cnt_q <= flash_cnt_d;
            colour_q    <= colour_d;
        end
    end

    // Latches, shifter transfer/shift and frame counter; a transfer sees the pre-edge latch values.
    always_comb begin
        bm_hold_d   = bm_hold_q;
        at_hold_d   = at_hold_q;
        shift_reg_d = {shift_reg_q[PIX_WIDTH-2:0], 1'b0};
        attr_reg_d  = attr_reg_q;
        disp_reg_d  = disp_reg_q;
        bord_reg_d  = bord_reg_q;
        flash_cnt_d = flash_cnt_q;

        if (bm_ld) begin
            bm_hold_d = PIX_WIDTH'(vdata);
        end
        if (at_ld) begin
            at_hold_d = ATTR_W'(vdata);
        end
        if (shift_ld) begin
            shift_reg_d = bm_hold_q;
            attr_reg_d  = at_hold_q;
            disp_reg_d  = disp_en;
            bord_reg_d  = border;
        end
        if (frame_sync) begin
            flash_cnt_d = flash_cnt_q + FLASH_BITS'(1);
        end
    end

    // Colour resolve: blanking beats border, border beats ink/paper.
    always_comb begin
        pix_c    = shift_reg_q[PIX_WIDTH-1] ^ (attr_reg_q[7] & flash_cnt_q[FLASH_BITS-1]);
        colour_d = '0;
        if (!n_blank) begin
            colour_d = '0;
        end else if (!disp_reg_q) begin
            colour_d = {1'b0, bord_reg_q};
        end else if (pix_c) begin
            colour_d = {attr_reg_q[6], attr_reg_q[2:0]};
        end else begin
            colour_d = {attr_reg_q[6], attr_reg_q[5:3]};
        end
    end

    assign colour      = colour_q;
    assign flash_phase = flash_cnt_q[FLASH_BITS-1];

endmodule

// File: tb/tb_ula_pixel_serializer.sv
// Scoreboard bench for ula_pixel_serializer: expected colours are queued as stimulus
// is driven and popped one per pixel clock.
module tb_ula_pixel_serializer;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       bm_ld, at_ld, shift_ld, disp_en, n_blank, frame_sync;
    logic [7:0] vdata;
    logic [2:0] border;
    logic [3:0] colour;
    logic       flash_phase;

    logic [3:0] exp_q[$];
    logic [3:0] exp_v;
    int         total = 0;
    int         bad   = 0;

    ula_pixel_serializer #(.FLASH_BITS(5), .PIX_WIDTH(8)) dut (
        .clk(clk), .n_reset(n_reset), .bm_ld(bm_ld), .at_ld(at_ld), .vdata(vdata),
        .shift_ld(shift_ld), .disp_en(disp_en), .border(border), .n_blank(n_blank),
        .frame_sync(frame_sync), .colour(colour), .flash_phase(flash_phase)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bm_ld = 0; at_ld = 0; shift_ld = 0; frame_sync = 0;
        vdata = 8'h00; n_blank = 1;
    endtask

    task automatic push_seq(input logic [31:0] seq);
        for (int i = 7; i >= 0; i--) exp_q.push_back(seq[i*4 +: 4]);
    endtask

    // Load both latches on separate edges, then hold shift_ld for the next edge (E0).
    task automatic load_latches(input logic [7:0] bm, input logic [7:0] at);
        bm_ld = 1; vdata = bm; tick();
        bm_ld = 0; at_ld = 1; vdata = at; tick();
        at_ld = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        disp_en = 0; border = 3'b000;
        n_reset = 0;
        #3;
        n_reset = 1;
        exp_q.delete();
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        disp_en = 0; border = 3'b000;
        n_reset = 0;
        tick(); tick();
        total++;
        if (colour !== 4'h0 || flash_phase !== 1'b0) begin
            bad++;
            $display("FAIL reset_state colour=%h phase=%b required colour=0 phase=0", colour, flash_phase);
        end
        n_reset = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (colour !== 4'h0) begin
                bad++;
                $display("FAIL reset_idle[%0d] colour=%h required 0", i, colour);
            end
        end
    endtask

    task automatic test_basic_shift();
        do_reset();
        load_latches(8'hA5, 8'h47);
        shift_ld = 1; disp_en = 1; tick();
        shift_ld = 0;
        push_seq(32'hF8F88F8F);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            total++;
            if (colour !== exp_v) begin
                bad++;
                $display("FAIL basic_shift[%0d] colour=%h required %h", i, colour, exp_v);
            end
        end
    endtask

    task automatic test_border();
        do_reset();
        load_latches(8'hC3, 8'h47);
        shift_ld = 1; disp_en = 0; border = 3'b010; tick();
        shift_ld = 0;
        push_seq(32'h22222222);
        push_seq(32'h22022222);
        for (int i = 0; i < 16; i++) begin
            shift_ld = (i == 7);
            n_blank  = !(i == 10);
            tick();
            exp_v = exp_q.pop_front();
            total++;
            if (colour !== exp_v) begin
                bad++;
                $display("FAIL border[%0d] colour=%h required %h", i, colour, exp_v);
            end
        end
        idle_inputs();
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_sync = 1; tick();
            frame_sync = 0;
        end
    endtask

    task automatic flash_row(input logic [31:0] seq, input string tag);
        load_latches(8'hF0, 8'h87);
        shift_ld = 1; disp_en = 1; tick();
        shift_ld = 0;
        push_seq(seq);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            total++;
            if (colour !== exp_v) begin
                bad++;
                $display("FAIL %s[%0d] colour=%h required %h", tag, i, colour, exp_v);
            end
        end
    endtask

    task automatic test_flash();
        do_reset();
        flash_row(32'h77770000, "flash_off");
        pulse_frames(15);
        total++;
        if (flash_phase !== 1'b0) begin
            bad++;
            $display("FAIL flash_15 phase=%b required 0", flash_phase);
        end
        pulse_frames(1);
        total++;
        if (flash_phase !== 1'b1) begin
            bad++;
            $display("FAIL flash_16 phase=%b required 1", flash_phase);
        end
        flash_row(32'h00007777, "flash_on");
        pulse_frames(16);
        total++;
        if (flash_phase !== 1'b0) begin
            bad++;
            $display("FAIL flash_wrap phase=%b required 0", flash_phase);
        end
        flash_row(32'h77770000, "flash_restored");
    endtask

    task automatic test_simultaneous_load();
        do_reset();
        load_latches(8'hFF, 8'h47);
        shift_ld = 1; bm_ld = 1; vdata = 8'h00; disp_en = 1; tick();
        shift_ld = 0; bm_ld = 0;
        push_seq(32'hFFFFFFFF);
        push_seq(32'h88888888);
        for (int i = 0; i < 16; i++) begin
            shift_ld = (i == 7);
            tick();
            exp_v = exp_q.pop_front();
            total++;
            if (colour !== exp_v) begin
                bad++;
                $display("FAIL simul_load[%0d] colour=%h required %h", i, colour, exp_v);
            end
        end
        shift_ld = 0;
    endtask

    task automatic test_early_reload();
        do_reset();
        load_latches(8'hA5, 8'h47);
        shift_ld = 1; disp_en = 1; tick();
        shift_ld = 0;
        exp_q.push_back(4'hF); exp_q.push_back(4'h8);
        exp_q.push_back(4'hF); exp_q.push_back(4'h8);
        push_seq(32'hF8888888);
        for (int i = 0; i < 12; i++) begin
            bm_ld    = (i == 0);
            vdata    = 8'h80;
            shift_ld = (i == 3);
            tick();
            exp_v = exp_q.pop_front();
            total++;
            if (colour !== exp_v) begin
                bad++;
                $display("FAIL early_reload[%0d] colour=%h required %h", i, colour, exp_v);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midline();
        do_reset();
        pulse_frames(16);
        load_latches(8'hFF, 8'h47);
        shift_ld = 1; disp_en = 1; tick();
        shift_ld = 0;
        tick(); tick();
        total++;
        if (colour !== 4'hF || flash_phase !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset colour=%h phase=%b required colour=f phase=1", colour, flash_phase);
        end
        #2;
        n_reset = 0;
        #1;
        total++;
        if (colour !== 4'h0 || flash_phase !== 1'b0) begin
            bad++;
            $display("FAIL async_reset colour=%h phase=%b required colour=0 phase=0", colour, flash_phase);
        end
        #1;
        n_reset = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (colour !== 4'h0 || flash_phase !== 1'b0) begin
                bad++;
                $display("FAIL post_reset[%0d] colour=%h phase=%b required 0/0", i, colour, flash_phase);
            end
        end
    endtask

    initial begin
        n_reset = 0;
        idle_inputs();
        disp_en = 0; border = 3'b000;
        test_reset();
        test_basic_shift();
        test_border();
        test_flash();
        test_simultaneous_load();
        test_early_reload();
        test_reset_midline();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ula_pixel_serializer.md
Name: ula_pixel_serializer

Overview:
- Video pixel stage of the ULA.
- Buffers the bitmap and attribute bytes fetched from screen RAM and serializes the bitmap MSB-first at pixel rate.
- Applies attribute ink/paper/bright/flash, substitutes the border colour outside the display window, and forces black during blanking.
- Feeds the colour-encoding inputs of ula_VideoDAC; one 4-bit colour index per pixel clock.

Parameters:
- FLASH_BITS, 5, width of the frame counter; flash phase is the counter MSB, so the default toggles every 16 frames.
- PIX_WIDTH, 8, bitmap byte width and number of shift positions.

Ports:
- clk  input  1  pixel clock (7 MHz domain); all state updates on the rising edge.
- n_reset  input  1  asynchronous active-low reset.
- bm_ld  input  1  load the bitmap holding latch from vdata.
- at_ld  input  1  load the attribute holding latch from vdata.
- vdata  input  8  video data bus from screen RAM fetch.
- shift_ld  input  1  transfer holding latches into the shifter/attribute registers (8-pixel boundary).
- disp_en  input  1  display window active; sampled at shift_ld.
- border  input  3  border colour, G R B; sampled at shift_ld.
- n_blank  input  1  0 = retrace blanking; sampled every cycle.
- frame_sync  input  1  one-cycle pulse per frame; advances the flash counter.
- colour  output  4  {bright, G, R, B}, registered.
- flash_phase  output  1  current flash phase (counter MSB).

Behaviour:
- Reset (async, n_reset=0):
  - Clears both holding latches, shift_reg, attr_reg, disp_reg, flash_cnt and colour.
  - colour=4'b0000 and flash_phase=0 during reset and until the first post-reset update.
- Holding latches:
  - On an edge with bm_ld=1: bm_hold <= vdata.
  - On an edge with at_ld=1: at_hold <= vdata.
  - bm_ld and at_ld asserted together: both latches load the same vdata.
- Transfer on an edge with shift_ld=1:
  - shift_reg <= bm_hold, attr_reg <= at_hold, disp_reg <= disp_en, bord_reg <= border.
  - The old (pre-edge) holding value is used; a bm_ld/at_ld on the same edge updates the latch only, for the next transfer.
- Shift on an edge with shift_ld=0: shift_reg <= {shift_reg[PIX_WIDTH-2:0], 1'b0}.
- Early transfer: shift_ld always wins over shift. A transfer arriving before 8 shifts discards the remaining bits.
- Pixel value is p = shift_reg[MSB] XOR (attr_reg[7] AND flash_phase).
- Colour, registered every edge:
  - n_blank=0 → 4'b0000.
  - Otherwise disp_reg=0 → {1'b0, bord_reg}.
  - Otherwise p=1 → {attr_reg[6], attr_reg[2:0]} (ink).
  - Otherwise → {attr_reg[6], attr_reg[5:3]} (paper).
- Latency:
  - Transfer at edge E0; bit7 appears on colour after E1, bit6 after E2, …, bit0 after E8.
  - With shift_ld every 8 cycles (E8 = next E0) the pixel stream is gap-free.
  - n_blank has a 1-cycle latency: it forces the colour register at the same edge it is sampled.
- Empty shifter (no transfer for more than 8 cycles): shifts in zeros, so paper colour (or border) persists.
- Flash counter:
  - frame_sync=1 at an edge → flash_cnt <= flash_cnt+1, modulo 2^FLASH_BITS; 31→0 wraps silently.
  - flash_phase = flash_cnt[FLASH_BITS-1], taken directly from the register with no extra delay.
  - The pixel pipeline uses the updated flash_phase from the next edge onward.
- frame_sync coincident with shift_ld or n_blank=0: all actions occur independently on the same edge.
- No other state: no handshake back-pressure; the upstream fetch timing owns strobe spacing.

Test Plan:
- Basic shift:
  - Stimulus: reset; bm_ld with vdata=8'hA5, at_ld with vdata=8'h47, then shift_ld with disp_en=1, n_blank=1.
  - Response: colour after E1..E8 = 7,0,7,0,0,7,0,7 with bright=1, i.e. 4'hF/4'h8 alternating per the pattern.
- Border:
  - Stimulus: disp_en=0, border=3'b010 at shift_ld.
  - Response: colour=4'b0010 for 8 cycles regardless of the bitmap.
  - Then n_blank=0 for 1 cycle → colour=0 at that edge only.
- Flash:
  - Stimulus: attr=8'h87, bitmap=8'hF0; issue 16 frame_sync pulses.
  - Response: flash_phase=1; pixels become paper,paper,paper,paper,ink×4 (0,0,0,0,7,7,7,7).
  - 16 more pulses → flash_phase=0 (wrap), original pattern restored.
- Simultaneous load:
  - Stimulus: bm_hold=8'hFF, then bm_ld (vdata=8'h00) on the same edge as shift_ld.
  - Response: 8 ink pixels shown; the next transfer shows 8 paper pixels.
- Early reload:
  - Stimulus: shift_ld 4 cycles after the previous one with new bitmap 8'h80.
  - Response: only 4 pixels of the old byte appear, then ink followed by 7 paper pixels.
- Reset mid-line:
  - Stimulus: assert n_reset=0 between clock edges during shifting.
  - Response: colour=0 immediately (asynchronous) and flash_phase=0.
  - After release with no strobes, colour stays 0 (disp_reg=0, bord_reg=0).
